// File: rtl/operand_forward_unit_if.sv
// Operand-forwarding bus: pipeline hazard inputs, register/bypass data, forwarded operands out.
// master drives the pipeline side, slave is the forwarding unit.
interface operand_forward_unit_if #(
   parameter int NBits   = 32,
   parameter int NAddr   = 5,
   parameter int CntBits = 16
);
   logic               Enable_i;
   logic               Clear_i;
   logic [NAddr-1:0]   Rs_i;
   logic [NAddr-1:0]   Rt_i;
   logic [NAddr-1:0]   ExMem_Rd_i;
   logic               ExMem_RegWrite_i;
   logic               ExMem_MemRead_i;
   logic [NAddr-1:0]   MemWb_Rd_i;
   logic               MemWb_RegWrite_i;
   logic [NBits-1:0]   RegFile_A_i;
   logic [NBits-1:0]   RegFile_B_i;
   logic [NBits-1:0]   ExMem_ALU_i;
   logic [NBits-1:0]   MemWb_Data_i;
   logic [NBits-1:0]   OperandA_o;
   logic [NBits-1:0]   OperandB_o;
   logic [1:0]         SelA_o;
   logic [1:0]         SelB_o;
   logic               Valid_o;
   logic               Stall_o;
   logic [CntBits-1:0] ForwardCount_o;

   modport master (
      output Enable_i, Clear_i, Rs_i, Rt_i, ExMem_Rd_i, ExMem_RegWrite_i, ExMem_MemRead_i,
             MemWb_Rd_i, MemWb_RegWrite_i, RegFile_A_i, RegFile_B_i, ExMem_ALU_i, MemWb_Data_i,
      input  OperandA_o, OperandB_o, SelA_o, SelB_o, Valid_o, Stall_o, ForwardCount_o
   );

   modport slave (
      input  Enable_i, Clear_i, Rs_i, Rt_i, ExMem_Rd_i, ExMem_RegWrite_i, ExMem_MemRead_i,
             MemWb_Rd_i, MemWb_RegWrite_i, RegFile_A_i, RegFile_B_i, ExMem_ALU_i, MemWb_Data_i,
      output OperandA_o, OperandB_o, SelA_o, SelB_o, Valid_o, Stall_o, ForwardCount_o
   );
endinterface

// File: rtl/operand_forward_unit.sv
// Selects EX/MEM or MEM/WB bypass data for operands A/B and registers them; one clock latency.
// Load-use hazard raises Stall_o combinationally and inserts exactly one bubble; Enable_i=0 holds.
module operand_forward_unit #(
   parameter int NBits   = 32,
   parameter int NAddr   = 5,
   parameter int CntBits = 16
) (
   input logic                    clk,
   input logic                    reset,
   operand_forward_unit_if.slave  bus
);
   typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

   localparam logic [1:0]         SelRf  = 2'b00;
   localparam logic [1:0]         SelWb  = 2'b01;
   localparam logic [1:0]         SelEx  = 2'b10;
   localparam logic [CntBits-1:0] CntMax = {CntBits{1'b1}};

   state_t             r_state;
   state_t             w_next_state;
   logic [NBits-1:0]   r_opa;
   logic [NBits-1:0]   r_opb;
   logic [1:0]         r_sela;
   logic [1:0]         r_selb;
   logic               r_valid;
   logic [CntBits-1:0] r_cnt;

   logic             w_ex_match_a;
   logic             w_ex_match_b;
   logic             w_wb_match_a;
   logic             w_wb_match_b;
   logic [1:0]       w_sela;
   logic [1:0]       w_selb;
   logic [NBits-1:0] w_opa;
   logic [NBits-1:0] w_opb;
   logic             w_load_use;
   logic             w_capture;
   logic             w_stall;
   logic             w_forwarded;

   // Register 0 is hardwired zero, so a write to it never forwards.
   assign w_ex_match_a = bus.ExMem_RegWrite_i && (bus.ExMem_Rd_i != '0) && (bus.ExMem_Rd_i == bus.Rs_i);
   assign w_ex_match_b = bus.ExMem_RegWrite_i && (bus.ExMem_Rd_i != '0) && (bus.ExMem_Rd_i == bus.Rt_i);
   assign w_wb_match_a = bus.MemWb_RegWrite_i && (bus.MemWb_Rd_i != '0) && (bus.MemWb_Rd_i == bus.Rs_i);
   assign w_wb_match_b = bus.MemWb_RegWrite_i && (bus.MemWb_Rd_i != '0) && (bus.MemWb_Rd_i == bus.Rt_i);

   assign w_sela = w_ex_match_a ? SelEx : (w_wb_match_a ? SelWb : SelRf);
   assign w_selb = w_ex_match_b ? SelEx : (w_wb_match_b ? SelWb : SelRf);

   assign w_opa = w_ex_match_a ? bus.ExMem_ALU_i : (w_wb_match_a ? bus.MemWb_Data_i : bus.RegFile_A_i);
   assign w_opb = w_ex_match_b ? bus.ExMem_ALU_i : (w_wb_match_b ? bus.MemWb_Data_i : bus.RegFile_B_i);

   assign w_load_use  = bus.ExMem_MemRead_i && (w_ex_match_a || w_ex_match_b);
   assign w_forwarded = (w_sela != SelRf) || (w_selb != SelRf);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // In STALL the EX/MEM slot holds the bubble, so the hazard check is skipped.
   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_stall      = 1'b0;
      case (r_state)
         RUN: begin
            if (bus.Enable_i) begin
               if (w_load_use) begin
                  w_stall      = 1'b1;
                  w_next_state = STALL;
               end else begin
                  w_capture = 1'b1;
               end
            end
         end
         STALL: begin
            if (bus.Enable_i) begin
               w_capture    = 1'b1;
               w_next_state = RUN;
            end
         end
         default: begin
            w_next_state = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_opa   <= '0;
         r_opb   <= '0;
         r_sela  <= SelRf;
         r_selb  <= SelRf;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_capture;
         if (w_capture) begin
            r_opa  <= w_opa;
            r_opb  <= w_opb;
            r_sela <= w_sela;
            r_selb <= w_selb;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (bus.Clear_i) begin
         r_cnt <= '0;
      end else if (w_capture && w_forwarded && (r_cnt != CntMax)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bus.OperandA_o     = r_opa;
   assign bus.OperandB_o     = r_opb;
   assign bus.SelA_o         = r_sela;
   assign bus.SelB_o         = r_selb;
   assign bus.Valid_o        = r_valid;
   assign bus.ForwardCount_o = r_cnt;
   assign bus.Stall_o        = w_stall && reset;
endmodule

// File: doc/operand_forward_unit.md
OPERAND_FORWARD_UNIT -- requirements
Module: operand_forward_unit

Interface
REQ-001 Parameter NBits, default 32, width of all data operands.
REQ-002 Parameter NAddr, default 5, width of register addresses.
REQ-003 Parameter CntBits, default 16, width of the forward-event counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 Enable_i  input  1  stage advance; 0 holds the stage.
REQ-007 Clear_i  input  1  synchronous clear of ForwardCount_o.
REQ-008 Rs_i, Rt_i  input  NAddr  source addresses of operands A and B.
REQ-009 ExMem_Rd_i  input  NAddr  EX/MEM destination; ExMem_RegWrite_i, ExMem_MemRead_i  input  1  its write and load flags.
REQ-010 MemWb_Rd_i  input  NAddr  MEM/WB destination; MemWb_RegWrite_i  input  1  its write flag.
REQ-011 RegFile_A_i, RegFile_B_i  input  NBits  register file read data.
REQ-012 ExMem_ALU_i  input  NBits  EX/MEM ALU result; MemWb_Data_i  input  NBits  MEM/WB write-back data.
REQ-013 OperandA_o, OperandB_o  output  NBits  registered forwarded operands.
REQ-014 SelA_o, SelB_o  output  2  registered selects used for the captured operands.
REQ-015 Valid_o  output  1  registered; operands captured on the previous edge.
REQ-016 Stall_o  output  1  combinational load-use stall request to upstream stages.
REQ-017 ForwardCount_o  output  CntBits  registered forward-event count.

Function
REQ-018 Per operand X (A: Rs_i, B: Rt_i): ExMatch = ExMem_RegWrite_i & ExMem_Rd_i!=0 & ExMem_Rd_i==X; WbMatch = MemWb_RegWrite_i & MemWb_Rd_i!=0 & MemWb_Rd_i==X.
REQ-019 Select encoding: 2'b00 register file, 2'b01 MemWb_Data_i, 2'b10 ExMem_ALU_i; 2'b11 never produced.
REQ-020 Select = 10 if ExMatch, else 01 if WbMatch, else 00 (EX/MEM priority over MEM/WB).
REQ-021 LoadUse = ExMem_MemRead_i & (ExMatch for A or ExMatch for B).
REQ-022 FSM states RUN and STALL; reset state RUN.
REQ-023 RUN, Enable_i=1, LoadUse=0: capture both operands and selects, Valid_o<=1, stay RUN.
REQ-024 RUN, Enable_i=1, LoadUse=1: Stall_o=1 same cycle, operands/selects hold, Valid_o<=0, next STALL.
REQ-025 STALL, Enable_i=1: LoadUse ignored (EX/MEM is a bubble), capture per REQ-020, Valid_o<=1, next RUN; exactly one stall cycle per hazard.
REQ-026 Stall_o=0 in STALL and whenever Enable_i=0.
REQ-027 Enable_i=0 in either state: state, operands, selects hold; Valid_o<=0.
REQ-028 ForwardCount_o increments by 1 on each capture where SelA or SelB !=00; saturates at all ones, no wrap.
REQ-029 Clear_i=1 zeroes ForwardCount_o on the next edge, overriding increment; other state unaffected.
REQ-030 Latency: one clock from input to OperandX_o/SelX_o/Valid_o; two clocks on a load-use hazard.

Reset
REQ-031 reset=0 asynchronously forces: state RUN, OperandA_o=OperandB_o=0, SelA_o=SelB_o=00, Valid_o=0, ForwardCount_o=0.
REQ-032 Reset asserted in STALL abandons the stall; first capture after release follows RUN rules.
REQ-033 Stall_o is 0 while reset=0.

Verification
REQ-034 Rs=3, ExMem_Rd=3, RegWrite=1, MemRead=0, ExMem_ALU=0xAAAA0000 -> next edge OperandA_o=0xAAAA0000, SelA_o=10, Valid_o=1, count=1.
REQ-035 Rs=Rt=5, ExMem_Rd=MemWb_Rd=5, both RegWrite=1 -> SelA_o=SelB_o=10 (priority); Rs=0 with both Rd=0 -> SelA_o=00.
REQ-036 Rt=7, ExMem_Rd=7, MemRead=1 -> Stall_o=1, Valid_o=0 next edge, state STALL; next cycle MemWb_Rd=7, MemWb_Data=0x12345678 -> OperandB_o=0x12345678, SelB_o=01, Valid_o=1.
REQ-037 Enable_i=0 for 3 cycles after a capture -> operands/selects unchanged, Valid_o=0, count unchanged.
REQ-038 CntBits=4, 17 forwarding captures -> ForwardCount_o=15; Clear_i=1 with concurrent forward -> 0.
REQ-039 reset=0 mid-STALL, mid-cycle -> all outputs zero immediately; after release, non-hazard input captured in one clock.
